set_job_host: RTL and testbench

- Initiator side of the set-counting engine interface: queues job descriptors from a system master, launches one job at a time into the engine, and collects each count.
- Returns every result with its job tag on a valid/ready result port.
- Rejects malformed jobs locally and recovers from a non-responding engine with a timeout.
- Sits between the control master and one set-counting engine instance.

---
 rtl/set_job_host.sv | 225 ++++++++++++++++++++++
 tb/tb_set_job_host.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_job_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | set_job_host: queues job descriptors, launches them one at a time into a |
// | set-counting engine and returns each count with its tag.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module set_job_host #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [23:0]      job_central,
  input  logic [11:0]      job_radius,
  input  logic [1:0]       job_mode,
  input  logic [TAG_W-1:0] job_tag,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             res_timeout,
  output logic [15:0]      stat_jobs,
  output logic [7:0]       stat_timeouts
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_TMR_W = $clog2(TIMEOUT) + 1;
  localparam int c_ENT_W = 24 + 12 + 2 + TAG_W;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic [23:0]      r_central;
  logic [11:0]      r_radius;
  logic [1:0]       r_mode;
  logic [TAG_W-1:0] r_res_tag;
  logic [7:0]       r_res_cand;
  logic             r_res_err;
  logic             r_res_tmo;
  logic [15:0]      r_stat_jobs;
  logic [7:0]       r_stat_tmo;
  logic             r_valid_q;
  logic [c_TMR_W-1:0] r_timer;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_rise;
  logic             w_tmo_hit;
  logic             w_set_en;
  logic             w_handshake;
  logic [c_ENT_W-1:0] w_head;
  logic [23:0]      w_head_central;
  logic [11:0]      w_head_radius;
  logic [1:0]       w_head_mode;
  logic [TAG_W-1:0] w_head_tag;
  logic             w_head_ok;
  logic             w_a_ok;
  logic             w_b_ok;
  logic             w_c_ok;

  function automatic logic in_range(input logic [3:0] v);
    return (v != 4'd0) && (v <= 4'd8);
  endfunction

  assign w_full   = (r_count == c_CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_push   = job_valid && !w_full;
  assign w_pop    = (r_state == S_IDLE) && !w_empty && !set_busy;
  assign w_rise   = set_valid && !r_valid_q;
  assign w_tmo_hit = (r_timer == c_TMR_LAST);
  assign w_handshake = (r_state == S_DONE) && res_ready;

  assign w_head = r_mem[r_rd_ptr];
  assign {w_head_central, w_head_radius, w_head_mode, w_head_tag} = w_head;

  // Circle A = top nibbles, B = middle, C = bottom of each packed bus.
  assign w_a_ok = in_range(w_head_radius[11:8]) && in_range(w_head_central[23:20])
                  && in_range(w_head_central[19:16]);
  assign w_b_ok = in_range(w_head_radius[7:4]) && in_range(w_head_central[15:12])
                  && in_range(w_head_central[11:8]);
  assign w_c_ok = in_range(w_head_radius[3:0]) && in_range(w_head_central[7:4])
                  && in_range(w_head_central[3:0]);

  always_comb begin
    w_head_ok = 1'b0;
    case (w_head_mode)
      2'd0:    w_head_ok = w_a_ok;
      2'd1:    w_head_ok = w_a_ok && w_b_ok;
      2'd2:    w_head_ok = w_a_ok && w_b_ok;
      default: w_head_ok = w_a_ok && w_b_ok && w_c_ok;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {job_central, job_radius, job_mode, job_tag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_set_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = w_head_ok ? S_LAUNCH : S_DONE;
      end
      S_LAUNCH: begin
        w_set_en    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_rise || w_tmo_hit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job register and result registers; rise takes priority over timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_central   <= '0;
      r_radius    <= '0;
      r_mode      <= '0;
      r_res_tag   <= '0;
      r_res_cand  <= '0;
      r_res_err   <= 1'b0;
      r_res_tmo   <= 1'b0;
      r_stat_jobs <= '0;
      r_stat_tmo  <= '0;
      r_valid_q   <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_valid_q <= set_valid;
      if (w_pop) begin
        r_central  <= w_head_central;
        r_radius   <= w_head_radius;
        r_mode     <= w_head_mode;
        r_res_tag  <= w_head_tag;
        r_res_cand <= '0;
        r_res_err  <= !w_head_ok;
        r_res_tmo  <= 1'b0;
      end
      if (r_state == S_LAUNCH) r_timer <= '0;
      if (r_state == S_WAIT) begin
        r_timer <= r_timer + c_TMR_W'(1);
        if (w_rise) begin
          r_res_cand <= set_candidate;
        end else if (w_tmo_hit) begin
          r_res_cand <= '0;
          r_res_tmo  <= 1'b1;
        end
      end
      if (w_handshake) begin
        r_res_err   <= 1'b0;
        r_res_tmo   <= 1'b0;
        r_stat_jobs <= r_stat_jobs + 16'd1;
        if (r_res_tmo && (r_stat_tmo != 8'hFF)) r_stat_tmo <= r_stat_tmo + 8'd1;
      end
    end
  end

  assign job_ready     = !w_full;
  assign set_en        = w_set_en;
  assign set_central   = r_central;
  assign set_radius    = r_radius;
  assign set_mode      = r_mode;
  assign res_valid     = (r_state == S_DONE);
  assign res_candidate = r_res_cand;
  assign res_tag       = r_res_tag;
  assign res_err       = r_res_err;
  assign res_timeout   = r_res_tmo;
  assign stat_jobs     = r_stat_jobs;
  assign stat_timeouts = r_stat_tmo;

endmodule
`default_nettype wire

// File: tb/tb_set_job_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_set_job_host: directed bench with a latency-programmable responder.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_set_job_host;

  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam int TIMEOUT    = 128;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [23:0]      job_central;
  logic [11:0]      job_radius;
  logic [1:0]       job_mode;
  logic [TAG_W-1:0] job_tag;
  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_busy;
  logic             set_valid;
  logic [7:0]       set_candidate;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             res_timeout;
  logic [15:0]      stat_jobs;
  logic [7:0]       stat_timeouts;

  int n_cmp  = 0;
  int n_fail = 0;

  int         eng_lat    = 80;
  logic [7:0] eng_ret    = 8'd29;
  bit         eng_mute   = 1'b0;
  int         eng_cnt;
  bit         eng_active;
  int         en_count   = 0;

  always #5 clk = ~clk;

  set_job_host #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TAG_W     (TAG_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_central  (job_central),
    .job_radius   (job_radius),
    .job_mode     (job_mode),
    .job_tag      (job_tag),
    .set_en       (set_en),
    .set_central  (set_central),
    .set_radius   (set_radius),
    .set_mode     (set_mode),
    .set_busy     (set_busy),
    .set_valid    (set_valid),
    .set_candidate(set_candidate),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_candidate(res_candidate),
    .res_tag      (res_tag),
    .res_err      (res_err),
    .res_timeout  (res_timeout),
    .stat_jobs    (stat_jobs),
    .stat_timeouts(stat_timeouts)
  );

  // Engine model: clears valid on launch, raises it eng_lat cycles later.
  always @(posedge clk) begin
    if (rst) begin
      set_busy      <= 1'b0;
      set_valid     <= 1'b0;
      set_candidate <= 8'd0;
      eng_active    <= 1'b0;
      eng_cnt       <= 0;
    end else if (set_en) begin
      en_count   <= en_count + 1;
      set_valid  <= 1'b0;
      set_busy   <= !eng_mute;
      eng_active <= !eng_mute;
      eng_cnt    <= 0;
    end else if (eng_active) begin
      if (eng_cnt == eng_lat - 1) begin
        set_valid     <= 1'b1;
        set_busy      <= 1'b0;
        set_candidate <= eng_ret;
        eng_active    <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] c, input logic [11:0] r,
                      input logic [1:0] m, input logic [TAG_W-1:0] t);
    int k;
    job_valid   = 1'b1;
    job_central = c;
    job_radius  = r;
    job_mode    = m;
    job_tag     = t;
    k = 0;
    while (!job_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("push_accept", job_ready, 1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_en(output int cyc);
    cyc = 0;
    while (!set_en && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("launch_seen", set_en, 1);
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("result_seen", res_valid, 1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    int n0;
    bit stable;
    logic [21:0] snap;

    rst = 1'b1;
    job_valid = 1'b0; job_central = '0; job_radius = '0; job_mode = '0;
    job_tag = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {set_en, set_central, set_radius, set_mode, res_valid, res_candidate,
                          res_tag, res_err, res_timeout, stat_jobs, stat_timeouts}, '0);
    check("rst_job_ready", job_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // 1: single mode-0 job, 80-cycle engine returning 29
    n0 = en_count;
    push(24'h440000, 12'h300, 2'd0, 4'd5);
    wait_en(c);
    check("t1_central", set_central, 24'h440000);
    check("t1_radius", set_radius, 12'h300);
    check("t1_mode", set_mode, 0);
    k = 0;
    while (!set_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t1_rise", set_valid, 1);
    check("t1_not_early", res_valid, 0);
    @(negedge clk);
    check("t1_latency", res_valid, 1);
    check("t1_cand", res_candidate, 29);
    check("t1_tag", res_tag, 5);
    check("t1_flags", {res_err, res_timeout}, 0);
    check("t1_one_launch", en_count - n0, 1);
    accept();
    check("t1_stat_jobs", stat_jobs, 1);
    check("t1_idle", res_valid, 0);

    // 2: five back-to-back jobs, queue fills while first is in flight
    eng_lat = 20;
    eng_ret = 8'h42;
    n0 = en_count;
    for (int t = 1; t <= 5; t++) push(24'h440000, 12'h300, 2'd0, 4'(t));
    check("t2_full", job_ready, 0);
    for (int t = 1; t <= 5; t++) begin
      wait_res(c);
      check("t2_tag", res_tag, t);
      check("t2_cand", res_candidate, 8'h42);
      accept();
    end
    check("t2_launches", en_count - n0, 5);
    check("t2_stat_jobs", stat_jobs, 6);

    // 3: malformed mode-1 job is rejected, mode-0 with rb=0 launches
    n0 = en_count;
    push(24'h444400, 12'h302, 2'd1, 4'd7);
    wait_res(c);
    check("t3_fast", c <= 2, 1);
    check("t3_err", res_err, 1);
    check("t3_cand", res_candidate, 0);
    check("t3_tag", res_tag, 7);
    check("t3_no_launch", en_count - n0, 0);
    accept();
    push(24'h440000, 12'h302, 2'd0, 4'd8);
    wait_res(c);
    check("t3b_err", res_err, 0);
    check("t3b_tag", res_tag, 8);
    check("t3b_cand", res_candidate, 8'h42);
    check("t3b_launch", en_count - n0, 1);
    accept();

    // 4: silent engine triggers timeout; next queued job still completes
    eng_mute = 1'b1;
    n0 = en_count;
    push(24'h440000, 12'h300, 2'd0, 4'd9);
    wait_en(c);
    push(24'h440000, 12'h300, 2'd0, 4'd10);
    k = 1;
    while (!res_valid && k < 1000) begin
      @(negedge clk);
      k++;
    end
    eng_mute = 1'b0;
    check("t4_tmo_cycles", k, TIMEOUT + 1);
    check("t4_timeout", res_timeout, 1);
    check("t4_cand", res_candidate, 0);
    check("t4_tag", res_tag, 9);
    check("t4_err", res_err, 0);
    accept();
    check("t4_stat_tmo", stat_timeouts, 1);
    wait_res(c);
    check("t4b_tag", res_tag, 10);
    check("t4b_cand", res_candidate, 8'h42);
    check("t4b_timeout", res_timeout, 0);
    check("t4b_launches", en_count - n0, 2);
    accept();
    check("t4b_stat_tmo", stat_timeouts, 1);

    // 5: result held under backpressure, queued job waits
    eng_ret = 8'h17;
    push(24'h440000, 12'h300, 2'd0, 4'd11);
    push(24'h440000, 12'h300, 2'd0, 4'd12);
    wait_res(c);
    snap = {res_candidate, res_tag, res_err, res_timeout, 8'h00};
    n0 = en_count;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || {res_candidate, res_tag, res_err, res_timeout, 8'h00} !== snap)
        stable = 1'b0;
    end
    check("t5_stable", stable, 1);
    check("t5_tag", res_tag, 11);
    check("t5_no_launch", en_count - n0, 0);
    accept();
    wait_en(c);
    check("t5_relaunch", c, 1);
    wait_res(c);
    check("t5b_tag", res_tag, 12);
    check("t5b_cand", res_candidate, 8'h17);
    accept();

    // 6: reset during WAIT drops everything; fresh job completes
    eng_ret = 8'h5A;
    push(24'h440000, 12'h300, 2'd0, 4'd13);
    push(24'h440000, 12'h300, 2'd0, 4'd14);
    wait_en(c);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outputs", {set_en, set_central, set_radius, set_mode, res_valid, res_candidate,
                             res_tag, res_err, res_timeout, stat_jobs, stat_timeouts}, '0);
    check("t6_job_ready", job_ready, 1);
    rst = 1'b0;
    n0 = en_count;
    repeat (5) @(negedge clk);
    check("t6_fifo_empty", en_count - n0, 0);
    push(24'h440000, 12'h300, 2'd0, 4'd15);
    wait_res(c);
    check("t6_tag", res_tag, 15);
    check("t6_cand", res_candidate, 8'h5A);
    accept();
    check("t6_stat_jobs", stat_jobs, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
